// File: rtl/pixel_channel_serializer.sv
// Buffers one packed pixel and streams its enabled channels one beat per cycle,
// forward or reverse, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | no pixel buffered, out_valid low
// SEND  | pixel buffered, out_valid high, current beat on out_*
module pixel_channel_serializer #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 3,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    in_rev,
    input  logic [NUM_CH-1:0]       in_ch_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDX_W-1:0]        out_ch,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        pix_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_CH*WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [NUM_CH-1:0]         mask_q, mask_d;
    logic                      rev_q, rev_d;
    logic [WIDTH-1:0]          out_data_q, out_data_d;
    logic [IDX_W-1:0]          out_ch_q, out_ch_d;
    logic                      out_first_q, out_first_d;
    logic                      out_last_q, out_last_d;
    logic                      drop_q, drop_d;
    logic [CNT_W-1:0]          pix_count_q, pix_count_d;

    logic                      accept;
    logic                      advance;
    logic [IDX_W-1:0]          first_idx;
    logic [IDX_W-1:0]          next_idx;

    // Start of a pixel: lowest enabled channel, or highest when reversed.
    function automatic logic [IDX_W-1:0] first_enabled(
        input logic [NUM_CH-1:0] mask,
        input logic              rev
    );
        logic [IDX_W-1:0] res;
        res = '0;
        if (rev) begin
            for (int i = 0; i < NUM_CH; i++)
                if (mask[i]) res = IDX_W'(i);
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (mask[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_enabled(
        input logic [NUM_CH-1:0] mask,
        input logic              rev,
        input logic [IDX_W-1:0]  cur
    );
        logic [IDX_W-1:0] res;
        res = cur;
        if (rev) begin
            for (int i = 0; i < NUM_CH; i++)
                if (mask[i] && (i < int'(cur))) res = IDX_W'(i);
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (mask[i] && (i > int'(cur))) res = IDX_W'(i);
        end
        return res;
    endfunction

    function automatic logic any_beyond(
        input logic [NUM_CH-1:0] mask,
        input logic              rev,
        input logic [IDX_W-1:0]  cur
    );
        logic res;
        res = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i] && (rev ? (i < int'(cur)) : (i > int'(cur))))
                res = 1'b1;
        end
        return res;
    endfunction

    // Mux by loop so an out-of-range index can never reach the data bus.
    function automatic logic [WIDTH-1:0] channel_data(
        input logic [NUM_CH*WIDTH-1:0] data,
        input logic [IDX_W-1:0]        idx
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (i == int'(idx)) res = data[i*WIDTH +: WIDTH];
        return res;
    endfunction

    assign out_valid  = (state_q == SEND);
    assign advance    = out_valid & out_ready;
    assign in_ready   = (state_q == IDLE) | (advance & out_last_q);
    assign accept     = in_valid & in_ready;
    assign first_idx  = first_enabled(in_ch_en, in_rev);
    assign next_idx   = next_enabled(mask_q, rev_q, out_ch_q);

    always_comb begin
        state_d     = state_q;
        buf_data_d  = buf_data_q;
        mask_d      = mask_q;
        rev_d       = rev_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        drop_d      = 1'b0;
        pix_count_d = pix_count_q;

        if (advance) begin
            if (out_last_q) begin
                pix_count_d = pix_count_q + 1'b1;
                state_d     = IDLE;
                out_first_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                out_ch_d    = next_idx;
                out_data_d  = channel_data(buf_data_q, next_idx);
                out_first_d = 1'b0;
                out_last_d  = ~any_beyond(mask_q, rev_q, next_idx);
            end
        end

        // Accept only happens in IDLE or on a completing last beat, so it
        // overrides whatever the advance branch chose.
        if (accept) begin
            buf_data_d = in_data;
            mask_d     = in_ch_en;
            rev_d      = in_rev;
            if (|in_ch_en) begin
                state_d     = SEND;
                out_ch_d    = first_idx;
                out_data_d  = channel_data(in_data, first_idx);
                out_first_d = 1'b1;
                out_last_d  = ~any_beyond(in_ch_en, in_rev, first_idx);
            end else begin
                state_d     = IDLE;
                drop_d      = 1'b1;
                out_first_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_data_q  <= '0;
            mask_q      <= '0;
            rev_q       <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            drop_q      <= 1'b0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_data_q  <= buf_data_d;
            mask_q      <= mask_d;
            rev_q       <= rev_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            drop_q      <= drop_d;
            pix_count_q <= pix_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign drop_pulse = drop_q;
    assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_pixel_channel_serializer.sv
// Directed bench for pixel_channel_serializer: default 3 x 8-bit channels,
// hand-computed beats for forward, reverse, back-to-back, stall, drop and reset.
module tb_pixel_channel_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_rev;
    logic [2:0]  in_ch_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_first;
    logic        out_last;
    logic        drop_pulse;
    logic [15:0] pix_count;

    int n_total = 0;
    int n_pass  = 0;

    pixel_channel_serializer #(
        .WIDTH(8), .NUM_CH(3), .IDX_W(2), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rev(in_rev), .in_ch_en(in_ch_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_first(out_first), .out_last(out_last),
        .drop_pulse(drop_pulse), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic [1:0] ch,
                            input logic first, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_ch"},    32'(out_ch),    32'(ch));
        chk({tag, "_first"}, 32'(out_first), 32'(first));
        chk({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_rev = 1'b0;
        in_ch_en = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_ch",    32'(out_ch),    32'd0);
        chk("rst_drop",  32'(drop_pulse), 32'd0);
        chk("rst_count", 32'(pix_count), 32'd0);
        reset = 1'b0;

        // 1: forward, full mask
        in_valid = 1'b1; in_data = 24'h3CB2A1; in_ch_en = 3'b111; in_rev = 1'b0;
        #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0; in_rev = 1'b1; in_ch_en = 3'b000;
        chk_beat("t1_b0", 8'hA1, 2'd0, 1'b1, 1'b0);
        tick(); chk_beat("t1_b1", 8'hB2, 2'd1, 1'b0, 1'b0);
        tick(); chk_beat("t1_b2", 8'h3C, 2'd2, 1'b0, 1'b1);
        tick();
        chk("t1_idle",  32'(out_valid), 32'd0);
        chk("t1_count", 32'(pix_count), 32'd1);

        // 2: reverse with skip of ch1
        in_valid = 1'b1; in_ch_en = 3'b101; in_rev = 1'b1;
        tick(); in_valid = 1'b0;
        chk_beat("t2_b0", 8'h3C, 2'd2, 1'b1, 1'b0);
        tick(); chk_beat("t2_b1", 8'hA1, 2'd0, 1'b0, 1'b1);
        tick();
        chk("t2_idle",  32'(out_valid), 32'd0);
        chk("t2_count", 32'(pix_count), 32'd2);

        // 3: back-to-back pixels, no bubble
        in_valid = 1'b1; in_ch_en = 3'b111; in_rev = 1'b0; in_data = 24'h3CB2A1;
        tick();
        chk_beat("t3_b0", 8'hA1, 2'd0, 1'b1, 1'b0);
        chk("t3_rdy0", 32'(in_ready), 32'd0);
        tick(); chk_beat("t3_b1", 8'hB2, 2'd1, 1'b0, 1'b0);
        in_data = 24'h665544;
        tick(); chk_beat("t3_b2", 8'h3C, 2'd2, 1'b0, 1'b1);
        chk("t3_rdy2", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        chk_beat("t3_b3", 8'h44, 2'd0, 1'b1, 1'b0);
        chk("t3_count_mid", 32'(pix_count), 32'd3);
        tick(); chk_beat("t3_b4", 8'h55, 2'd1, 1'b0, 1'b0);
        tick(); chk_beat("t3_b5", 8'h66, 2'd2, 1'b0, 1'b1);
        chk("t3_rdy5", 32'(in_ready), 32'd1);
        tick();
        chk("t3_idle",  32'(out_valid), 32'd0);
        chk("t3_count", 32'(pix_count), 32'd4);

        // 4: backpressure on ch1 for 4 cycles
        in_valid = 1'b1; in_data = 24'h3CB2A1; in_ch_en = 3'b111;
        tick(); in_valid = 1'b0;
        chk_beat("t4_b0", 8'hA1, 2'd0, 1'b1, 1'b0);
        tick(); out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_beat("t4_stall", 8'hB2, 2'd1, 1'b0, 1'b0);
            chk("t4_stall_rdy", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        chk_beat("t4_resume", 8'hB2, 2'd1, 1'b0, 1'b0);
        tick(); chk_beat("t4_b2", 8'h3C, 2'd2, 1'b0, 1'b1);
        tick();
        chk("t4_count", 32'(pix_count), 32'd5);

        // 5: zero mask is dropped
        in_valid = 1'b1; in_ch_en = 3'b000;
        tick(); in_valid = 1'b0;
        chk("t5_drop",  32'(drop_pulse), 32'd1);
        chk("t5_valid", 32'(out_valid),  32'd0);
        chk("t5_rdy",   32'(in_ready),   32'd1);
        chk("t5_count", 32'(pix_count),  32'd5);
        tick();
        chk("t5_drop_end", 32'(drop_pulse), 32'd0);
        chk("t5_valid2",   32'(out_valid),  32'd0);

        // single enabled channel, reversed: first and last on the only beat
        in_valid = 1'b1; in_ch_en = 3'b010; in_rev = 1'b1;
        tick(); in_valid = 1'b0;
        chk_beat("single", 8'hB2, 2'd1, 1'b1, 1'b1);
        tick();
        chk("single_idle",  32'(out_valid), 32'd0);
        chk("single_count", 32'(pix_count), 32'd6);

        // 6: reset after the first beat
        in_valid = 1'b1; in_ch_en = 3'b111; in_rev = 1'b0;
        tick(); in_valid = 1'b0;
        chk_beat("t6_b0", 8'hA1, 2'd0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_count", 32'(pix_count), 32'd0);
        chk("t6_rdy",   32'(in_ready),  32'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_residual", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pixel_channel_serializer.md
Name: pixel_channel_serializer

Overview:
- Parametrised successor to the fixed three-way R/G/B buffer multiplexer.
- Accepts one packed pixel of NUM_CH channels through a valid/ready handshake and holds it in a one-entry buffer.
- Emits the enabled channels one per cycle, in forward or reverse order, through a second valid/ready handshake.
- Sits between the pixel line buffer and the byte-serial display interface of the adaptor.

Parameters:
WIDTH, 8, bits per colour channel
NUM_CH, 3, channels per pixel (ch0=R, ch1=G, ch2=B for the default)
IDX_W, 2, width of the channel index; must be max(1, clog2(NUM_CH))
CNT_W, 16, width of the emitted-pixel counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  pixel word valid
in_ready  output  1  block can accept a pixel this cycle
in_data  input  NUM_CH*WIDTH  packed pixel; channel k at bits [k*WIDTH +: WIDTH]
in_rev  input  1  1 = emit highest enabled channel first; sampled with the pixel
in_ch_en  input  NUM_CH  per-channel enable mask; sampled with the pixel
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  current channel value
out_ch  output  IDX_W  index of the current channel
out_first  output  1  current beat is the first enabled channel of the pixel
out_last  output  1  current beat is the last enabled channel of the pixel
drop_pulse  output  1  one-cycle pulse: accepted pixel had an all-zero mask
pix_count  output  CNT_W  count of pixels whose last beat completed; wraps

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out_valid, out_first, out_last, drop_pulse = 0; out_data, out_ch, pix_count = 0; buffered pixel, mask and rev cleared.
- Reset during SEND discards the buffered pixel. No further beats are emitted.
- FSM states:
  - IDLE: no pixel buffered.
  - SEND: pixel buffered and out_valid=1.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back pixels with no bubble.
- Accept occurs when in_valid & in_ready. At the accept edge, latch in_data, in_ch_en and in_rev.
- If the latched mask is non-zero:
  - Next state is SEND.
  - out_valid=1 from the next cycle, so latency is 1 cycle from accept to first beat.
  - The first beat is the lowest enabled index, or the highest when rev=1.
  - out_first=1 on that beat.
- If the latched mask is zero:
  - No beats are emitted.
  - drop_pulse=1 for exactly the next cycle.
  - State returns to or stays IDLE; pix_count is unchanged.
- Beat advance occurs when out_valid & out_ready:
  - When out_last=0: move to the next enabled index in the latched direction, skipping disabled channels. out_first=0.
  - When out_last=1: pix_count increments (wraps at 2^CNT_W).
    - If a new pixel is accepted in the same cycle, load it as above.
    - Otherwise go to IDLE and set out_valid=0.
- Stall: while out_valid & ~out_ready, out_data, out_ch, out_first and out_last are held stable. in_ready=0 during the stall.
- out_last is 1 when no enabled channel remains beyond the current one in the latched direction.
  - A single-enabled-channel pixel has out_first = out_last = 1 on its only beat.
- out_data, out_ch, out_first and out_last are registered outputs. No combinational path exists from in_* to out_*.
- The only combinational path from out_ready is to in_ready.
- in_rev and in_ch_en are ignored except at the accept edge. Changing them mid-pixel has no effect.
- No invalid select state exists: every emitted beat corresponds to an enabled channel. out_data never holds a stale value from an unselected input.

Test Plan:
1. Forward, full mask: NUM_CH=3, in_data=0x3C_B2_A1 (B=3C,G=B2,R=A1), en=3'b111, rev=0, out_ready=1 -> beats A1/ch0/first, B2/ch1, 3C/ch2/last on cycles N+1..N+3; pix_count=1.
2. Reverse with skip: same data, en=3'b101, rev=1 -> beats 3C/ch2/first, then A1/ch0/last; exactly 2 beats; ch1 never appears.
3. Back-to-back: two pixels offered continuously with out_ready=1 -> in_ready=1 on each last beat; 6 consecutive valid beats with no bubble; pix_count=2.
4. Backpressure: out_ready=0 for 4 cycles on beat ch1 -> out_data=B2 and out_ch=1 held for 4 cycles; in_ready=0 throughout; the sequence resumes unchanged.
5. Zero mask: en=3'b000 accepted -> drop_pulse=1 for one cycle; out_valid stays 0; pix_count unchanged; in_ready=1 on the following cycle.
6. Reset mid-pixel: assert reset after the first beat of 0x3C_B2_A1 -> the next cycle shows out_valid=0, pix_count=0, in_ready=1; no residual beats after reset deasserts.
